// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer for the accumulator CPU.
// It drives one registered 32-bit control word per cycle for the datapath and ALU.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [7:0]  ir_opcode,
  input  logic [7:0]  flag,
  output logic [31:0] control_signal,
  output logic        instr_done,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_DEC  = 4'd4,
    S_E0   = 4'd5,
    S_E1   = 4'd6,
    S_E2   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h09;
  localparam logic [7:0] OP_OR     = 8'h0A;
  localparam logic [7:0] OP_NOT    = 8'h0B;
  localparam logic [7:0] OP_SHR    = 8'h0C;
  localparam logic [7:0] OP_SHL    = 8'h0D;
  localparam logic [7:0] OP_ASR    = 8'h0E;
  localparam logic [7:0] OP_ASL    = 8'h0F;

  state_t      state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        done_q, done_d;
  logic        halted_q, halted_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  op;
  logic        is_store, is_operand;
  state_t      end_st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
      halted_q <= halted_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    // Outputs are registered, so the word is decoded from the state being entered;
    // on the DEC exit edge the live opcode is used because the latch updates on that same edge.
    op         = (state_q == S_DEC) ? ir_opcode : opcode_q;
    opcode_d   = op;
    is_store   = (op == OP_STORE);
    is_operand = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
                 (op == OP_MPY)  || (op == OP_AND) || (op == OP_OR);
    end_st     = run ? S_F0 : S_IDLE;

    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = run ? S_F0 : S_IDLE;
      S_F0:    state_d = S_F1;
      S_F1:    state_d = S_F2;
      S_F2:    state_d = S_DEC;
      S_DEC:   state_d = (op == OP_HALT) ? S_HALT : S_E0;
      S_E0:    state_d = (is_store || is_operand) ? S_E1 : end_st;
      S_E1:    state_d = is_store ? end_st : S_E2;
      S_E2:    state_d = end_st;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    ctrl_d = '0;
    done_d = 1'b0;
    case (state_d)
      S_F0:  ctrl_d[0] = 1'b1;
      S_F1:  begin ctrl_d[1] = 1'b1; ctrl_d[3] = 1'b1; end
      S_F2:  ctrl_d[2] = 1'b1;
      S_DEC: ctrl_d[4] = 1'b1;
      S_E0: begin
        done_d = !(is_store || is_operand);
        case (op)
          OP_STORE:  ctrl_d[6] = 1'b1;
          OP_LOAD, OP_ADD, OP_SUB, OP_MPY, OP_AND, OP_OR: ctrl_d[1] = 1'b1;
          OP_NOT:    begin ctrl_d[26] = 1'b1; ctrl_d[8] = 1'b1; end
          OP_SHR:    begin ctrl_d[28] = 1'b1; ctrl_d[8] = 1'b1; end
          OP_SHL:    begin ctrl_d[27] = 1'b1; ctrl_d[8] = 1'b1; end
          OP_ASR:    begin ctrl_d[31] = 1'b1; ctrl_d[8] = 1'b1; end
          OP_ASL:    begin ctrl_d[30] = 1'b1; ctrl_d[8] = 1'b1; end
          OP_JMP:    ctrl_d[9] = 1'b1;
          OP_JMPGEZ: ctrl_d[9] = ~flag[0];
          default:   ctrl_d = '0;
        endcase
      end
      S_E1: begin
        done_d = is_store;
        if (is_store) ctrl_d[7] = 1'b1;
        else          ctrl_d[5] = 1'b1;
      end
      S_E2: begin
        done_d    = 1'b1;
        ctrl_d[8] = 1'b1;
        case (op)
          OP_LOAD: begin ctrl_d[21] = 1'b1; ctrl_d[22] = 1'b1; end
          OP_ADD:  ctrl_d[22] = 1'b1;
          OP_SUB:  ctrl_d[23] = 1'b1;
          OP_AND:  ctrl_d[24] = 1'b1;
          OP_OR:   ctrl_d[25] = 1'b1;
          OP_MPY:  begin ctrl_d[29] = 1'b1; ctrl_d[16] = 1'b1; ctrl_d[10] = 1'b1; end
          default: ctrl_d[8] = 1'b1;
        endcase
      end
      S_HALT:  done_d = (state_q != S_HALT);
      default: ctrl_d = '0;
    endcase

    halted_d = halted_q | (state_d == S_HALT);
  end

  assign control_signal = ctrl_q;
  assign instr_done     = done_q;
  assign halted         = halted_q;
  assign state          = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares whenever the FSM is out of IDLE.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  ir_opcode;
  logic [7:0]  flag;
  logic [31:0] control_signal;
  logic        instr_done;
  logic        halted;
  logic [3:0]  state;

  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] w;
    logic        dn;
    logic        hl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode), .flag(flag),
    .control_signal(control_signal), .instr_done(instr_done),
    .halted(halted), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && state != 4'd0) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: state=%0d word=0x%08h with empty scoreboard", state, control_signal);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("cycle", {27'd0, state, control_signal, instr_done, halted},
              {27'd0, e.st, e.w, e.dn, e.hl});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int instr_len(input logic [7:0] op);
    case (op)
      8'h01: return 6;
      8'h02, 8'h03, 8'h04, 8'h08, 8'h09, 8'h0A: return 7;
      default: return 5;
    endcase
  endfunction

  // Called when the next rising edge enters F0; leaves the bench in the last pushed cycle.
  task automatic do_instr(input logic [7:0] op, input logic [7:0] fl,
                          input int n_edges, input int n_push, input int drop_at);
    logic [31:0] w[7];
    int len;
    len  = instr_len(op);
    w[0] = 32'h1; w[1] = 32'hA; w[2] = 32'h4; w[3] = 32'h10;
    w[4] = 32'h0; w[5] = 32'h0; w[6] = 32'h0;
    case (op)
      8'h01: begin w[4] = 32'h40; w[5] = 32'h80; end
      8'h02: begin w[4] = 32'h2; w[5] = 32'h20; w[6] = 32'h00600100; end
      8'h03: begin w[4] = 32'h2; w[5] = 32'h20; w[6] = 32'h00400100; end
      8'h04: begin w[4] = 32'h2; w[5] = 32'h20; w[6] = 32'h00800100; end
      8'h09: begin w[4] = 32'h2; w[5] = 32'h20; w[6] = 32'h01000100; end
      8'h0A: begin w[4] = 32'h2; w[5] = 32'h20; w[6] = 32'h02000100; end
      8'h08: begin w[4] = 32'h2; w[5] = 32'h20; w[6] = 32'h20010500; end
      8'h0B: w[4] = 32'h04000100;
      8'h0C: w[4] = 32'h10000100;
      8'h0D: w[4] = 32'h08000100;
      8'h0E: w[4] = 32'h80000100;
      8'h0F: w[4] = 32'h40000100;
      8'h06: w[4] = 32'h200;
      8'h05: w[4] = fl[0] ? 32'h0 : 32'h200;
      default: w[4] = 32'h0;
    endcase
    ir_opcode = op;
    flag      = fl;
    for (int i = 0; i < len && i < n_push; i++) begin
      exp_t e;
      e.st = 4'(i + 1);
      e.w  = w[i];
      e.dn = (i == len - 1);
      e.hl = 1'b0;
      q.push_back(e);
    end
    for (int i = 1; i <= n_edges; i++) begin
      step();
      if (i == drop_at) run = 1'b0;
      if (i == 5 && len > 5) ir_opcode = 8'hAA;
    end
  endtask

  initial begin
    logic [7:0] prog[15];
    logic [7:0] flg[15];
    rst = 1'b1; run = 1'b0; ir_opcode = 8'h00; flag = 8'h00;
    #1;
    check("reset_outputs", {27'd0, state, control_signal, instr_done, halted}, 64'd0);
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    check("idle_run0_state", {60'd0, state}, 64'd0);

    prog = '{8'h02, 8'h03, 8'h08, 8'h0E, 8'h05, 8'h05, 8'h06, 8'h01,
             8'h04, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0F};
    flg  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run = 1'b1;
    for (int k = 0; k < 15; k++)
      do_instr(prog[k], flg[k], instr_len(prog[k]), 7, 0);

    do_instr(8'hFF, 8'h00, 5, 5, 2);
    step(); step();
    check("idle_after_run_drop", {60'd0, state}, 64'd0);

    run = 1'b1;
    do_instr(8'h02, 8'h00, 6, 5, 0);
    rst = 1'b1;
    #1;
    check("async_reset_mid_e1", {27'd0, state, control_signal, instr_done, halted}, 64'd0);
    step();
    rst = 1'b0;
    run = 1'b0;
    step(); step(); step();
    check("idle_after_reset", {28'd0, state, control_signal}, 64'd0);

    run = 1'b1;
    ir_opcode = 8'h07;
    begin
      exp_t e;
      e.hl = 1'b0; e.dn = 1'b0;
      e.st = 4'd1; e.w = 32'h1;  q.push_back(e);
      e.st = 4'd2; e.w = 32'hA;  q.push_back(e);
      e.st = 4'd3; e.w = 32'h4;  q.push_back(e);
      e.st = 4'd4; e.w = 32'h10; q.push_back(e);
      e.st = 4'd8; e.w = 32'h0; e.dn = 1'b1; e.hl = 1'b1; q.push_back(e);
      for (int i = 0; i < 5; i++) step();
      e.dn = 1'b0;
      for (int i = 0; i < 10; i++) q.push_back(e);
      for (int i = 0; i < 10; i++) begin
        run = ~run;
        step();
      end
    end
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    check("halt_sticky", {59'd0, halted, state}, {59'd0, 1'b1, 4'd8});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
